// File: rtl/non_restoring_divn.sv
// Sequential non-restoring divider, one quotient bit per clock.
// Signed or unsigned by parameter; flags divide-by-zero and MIN/-1 overflow.
module non_restoring_divn #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             bgn,
    input  logic [WIDTH-1:0] ibusa,
    input  logic [WIDTH-1:0] ibusb,
    output logic             busy,
    output logic             stop,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        CORR,
        FIX
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] mag_b;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             dz_p;
    logic             ovf_p;

    logic             sign_a;
    logic             sign_b;
    logic             zero_b;
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   step;

    assign busy = (state != IDLE);

    // Operand magnitudes and the add/subtract step of one iteration.
    always_comb begin
        sign_a   = SIGNED && ibusa[WIDTH-1];
        sign_b   = SIGNED && ibusb[WIDTH-1];
        zero_b   = (ibusb == '0);
        mag_a_in = sign_a ? (~ibusa + 1'b1) : ibusa;
        mag_b_in = sign_b ? (~ibusb + 1'b1) : ibusb;
        shifted  = {acc[WIDTH-1:0], quo[WIDTH-1]};
        if (acc[WIDTH])
            step = shifted + {1'b0, mag_b};
        else
            step = shifted - {1'b0, mag_b};
    end

    // Next-state logic; a zero divisor skips straight to the result stage.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bgn) state_nxt = zero_b ? FIX : ITER;
            ITER: if (cnt == LAST) state_nxt = CORR;
            CORR: state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Datapath: capture, iterate, restore, then publish signed results.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc       <= '0;
            quo       <= '0;
            mag_b     <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz_p      <= 1'b0;
            ovf_p     <= 1'b0;
            stop      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            stop <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bgn) begin
                        acc   <= '0;
                        cnt   <= '0;
                        mag_b <= mag_b_in;
                        neg_q <= sign_a ^ sign_b;
                        neg_r <= sign_a;
                        dz_p  <= zero_b;
                        ovf_p <= SIGNED && (ibusa == MIN_VAL) && (ibusb == '1);
                        quo   <= zero_b ? ibusa : mag_a_in;
                    end
                end
                ITER: begin
                    acc <= step;
                    quo <= {quo[WIDTH-2:0], ~step[WIDTH]};
                    cnt <= cnt + 1'b1;
                end
                CORR: begin
                    if (acc[WIDTH])
                        acc <= acc + {1'b0, mag_b};
                end
                FIX: begin
                    stop <= 1'b1;
                    dbz  <= dz_p;
                    ovf  <= ovf_p;
                    if (dz_p) begin
                        quotient  <= '1;
                        remainder <= quo;
                    end else begin
                        quotient  <= neg_q ? (~quo + 1'b1) : quo;
                        remainder <= neg_r ? (~acc[WIDTH-1:0] + 1'b1)
                                           : acc[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
